// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with per-register busy
// scoreboard, write-to-read bypass and a configurable number of read ports.

// One combinational read port: zero-register override, then bypass, then array.
module regfile_rd_port #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic [NREG*XLEN-1:0] mem,
  input  logic [NREG-1:0]      busy,
  input  logic [AW-1:0]        raddr,
  input  logic                 wr_en,
  input  logic [AW-1:0]        waddr,
  input  logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      rdata,
  output logic                 rbusy
);
  logic is_zero;

  assign is_zero = (ZERO_REG != 0) && (raddr == '0);

  // Hardwired zero beats bypass; bypass beats stored state.
  always_comb begin
    rdata = mem[int'(raddr)*XLEN +: XLEN];
    rbusy = busy[raddr];
    if (is_zero) begin
      rdata = '0;
      rbusy = 1'b0;
    end else if (wr_en && (waddr == raddr)) begin
      rdata = wdata;
      rbusy = 1'b0;
    end
  end
endmodule

module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              wr_en,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ok,
  output logic [NREG-1:0]   busy_vec,
  output logic              err
);
  logic [NREG-1:0][XLEN-1:0] mem;
  logic [NREG-1:0]           busy;
  logic [NREG-1:0]           busy_nxt;
  logic                      wr_hit;
  logic                      iss_fire;

  // Writes and issues to the hardwired zero register are dropped here, so
  // entry 0 stays zero and never busy without extra read-side logic.
  assign wr_hit   = wr_en && !((ZERO_REG != 0) && (waddr == '0));
  // A retiring write to the same register frees it for re-issue this cycle.
  assign iss_ok   = !busy[iss_addr] || (wr_en && (waddr == iss_addr));
  assign iss_fire = iss_en && iss_ok && !((ZERO_REG != 0) && (iss_addr == '0));
  assign busy_vec = busy;

  // Next scoreboard: writeback clears, issue sets; set wins on a collision.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit)   busy_nxt[waddr]    = 1'b0;
    if (iss_fire) busy_nxt[iss_addr] = 1'b1;
  end

  // Data array update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       mem        <= '0;
    else if (wr_hit) mem[waddr] <= wdata;
  end

  // Scoreboard update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Sticky error: writeback to a register nobody issued. A same-edge re-issue
  // of that register does not count as a stray write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err <= 1'b0;
    else if (wr_hit && !busy[waddr] && !(iss_fire && (iss_addr == waddr)))
      err <= 1'b1;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    regfile_rd_port #(
      .XLEN(XLEN), .NREG(NREG), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_rd (
      .mem   (mem),
      .busy  (busy),
      .raddr (raddr[g*AW +: AW]),
      .wr_en (wr_en),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rdata[g*XLEN +: XLEN]),
      .rbusy (rbusy[g])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic
// against an array-based reference model; second instance for a wide sweep.
module tb_regfile_scoreboard;
  localparam int XLEN = 32, NREG = 32, NRD = 2, AW = 5;
  localparam int XB = 64, NB = 16, RB = 4, AB = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                wr_en, iss_en, iss_ok, err;
  logic [AW-1:0]       waddr, iss_addr;
  logic [XLEN-1:0]     wdata;
  logic [NREG-1:0]     busy_vec;

  logic [RB*AB-1:0]    raddr_b;
  logic [RB*XB-1:0]    rdata_b;
  logic [RB-1:0]       rbusy_b;
  logic                wr_en_b, iss_en_b, iss_ok_b, err_b;
  logic [AB-1:0]       waddr_b, iss_addr_b;
  logic [XB-1:0]       wdata_b;
  logic [NB-1:0]       busy_vec_b;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1)) dut (
    .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .iss_en(iss_en),
    .iss_addr(iss_addr), .iss_ok(iss_ok), .busy_vec(busy_vec), .err(err)
  );

  regfile_scoreboard #(.XLEN(XB), .NREG(NB), .NRD(RB), .ZERO_REG(1)) dut_b (
    .clock(clock), .reset(reset), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .wr_en(wr_en_b), .waddr(waddr_b), .wdata(wdata_b), .iss_en(iss_en_b),
    .iss_addr(iss_addr_b), .iss_ok(iss_ok_b), .busy_vec(busy_vec_b), .err(err_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural contents, busy set and sticky error.
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_busy[NREG];
  bit              m_err;

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin m_reg[r] = '0; m_busy[r] = 0; end
    m_err = 0;
  endtask

  function automatic logic [XLEN-1:0] exp_rdata(int a);
    if (a == 0) return '0;
    if (wr_en && int'(waddr) == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic logic exp_rbusy(int a);
    if (a == 0) return 1'b0;
    if (wr_en && int'(waddr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_iss_ok();
    return !m_busy[iss_addr] || (wr_en && waddr == iss_addr);
  endfunction

  function automatic logic [NREG-1:0] exp_bv();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Apply one clock edge's worth of rules to the model.
  task automatic model_step();
    bit ok, wr_hit, fire;
    if (reset) return;
    ok     = exp_iss_ok();
    wr_hit = wr_en && waddr != 0;
    fire   = iss_en && ok && iss_addr != 0;
    if (wr_hit && !m_busy[waddr] && !(fire && iss_addr == waddr)) m_err = 1;
    if (wr_hit) begin m_reg[waddr] = wdata; m_busy[waddr] = 0; end
    if (fire) m_busy[iss_addr] = 1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; iss_en = 0; waddr = '0; wdata = '0; iss_addr = '0;
    wr_en_b = 0; iss_en_b = 0; waddr_b = '0; wdata_b = '0; iss_addr_b = '0;
  endtask

  task automatic test_reset();
    idle(); raddr = {5'd4, 5'd1}; raddr_b = '0;
    reset = 1; model_reset();
    #3;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy_vec); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
    checks++; if (rdata !== '0 || rbusy !== '0) begin errors++; $display("FAIL reset_rd: got %h/%b exp 0/0", rdata, rbusy); end
    checks++; if (iss_ok !== 1'b1) begin errors++; $display("FAIL reset_iss_ok: got %b exp 1", iss_ok); end
    @(negedge clock); reset = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    wr_en = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr[0 +: AW] = 5;
    tick(); idle();
    checks++; if (rdata[0 +: XLEN] !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_pre_rd: got %h exp deadbeef", rdata[0 +: XLEN]); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mid_pre_err: got %b exp 1", err); end
    #2 reset = 1; model_reset();
    #1;
    checks++; if (rdata[0 +: XLEN] !== '0) begin errors++; $display("FAIL mid_rd: got %h exp 0", rdata[0 +: XLEN]); end
    checks++; if (busy_vec !== '0 || err !== 1'b0) begin errors++; $display("FAIL mid_state: got %h/%b exp 0/0", busy_vec, err); end
    @(negedge clock); reset = 0;
    tick();
  endtask

  task automatic test_issue_wb();
    iss_en = 1; iss_addr = 7; raddr = {5'd7, 5'd7};
    #1;
    checks++; if (iss_ok !== 1'b1) begin errors++; $display("FAIL iss7_ok: got %b exp 1", iss_ok); end
    tick(); iss_en = 0;
    checks++; if (busy_vec[7] !== 1'b1 || rbusy[0] !== 1'b1) begin errors++; $display("FAIL iss7_busy: got %b/%b exp 1/1", busy_vec[7], rbusy[0]); end
    iss_en = 1; #1;
    checks++; if (iss_ok !== 1'b0) begin errors++; $display("FAIL iss7_waw: got %b exp 0", iss_ok); end
    tick(); iss_en = 0;
    checks++; if (busy_vec !== exp_bv()) begin errors++; $display("FAIL iss7_hold: got %h exp %h", busy_vec, exp_bv()); end
    wr_en = 1; waddr = 7; wdata = 32'h12345678; #1;
    checks++; if (rdata[XLEN +: XLEN] !== 32'h12345678 || rbusy[1] !== 1'b0) begin errors++; $display("FAIL wb7_bypass: got %h/%b exp 12345678/0", rdata[XLEN +: XLEN], rbusy[1]); end
    tick(); idle();
    checks++; if (busy_vec[7] !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL wb7_after: got %b/%b exp 0/0", busy_vec[7], err); end
  endtask

  task automatic test_same_edge();
    iss_en = 1; iss_addr = 3; tick(); idle();
    wr_en = 1; waddr = 3; wdata = 32'hA5A5A5A5; iss_en = 1; iss_addr = 3; raddr = {5'd0, 5'd3};
    #1;
    checks++; if (iss_ok !== 1'b1) begin errors++; $display("FAIL same_ok: got %b exp 1", iss_ok); end
    tick(); idle();
    checks++; if (rdata[0 +: XLEN] !== 32'hA5A5A5A5 || busy_vec[3] !== 1'b1 || err !== 1'b0)
      begin errors++; $display("FAIL same_after: got %h/%b/%b exp a5a5a5a5/1/0", rdata[0 +: XLEN], busy_vec[3], err); end
    wr_en = 1; waddr = 3; wdata = 32'h0; tick(); idle();
  endtask

  task automatic test_zero();
    wr_en = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0}; #1;
    checks++; if (rdata !== '0 || rbusy !== '0) begin errors++; $display("FAIL zero_bypass: got %h/%b exp 0/0", rdata, rbusy); end
    tick(); idle(); raddr = {5'd0, 5'd0};
    checks++; if (rdata !== '0) begin errors++; $display("FAIL zero_rd: got %h exp 0", rdata); end
    iss_en = 1; iss_addr = 0; #1;
    checks++; if (iss_ok !== 1'b1) begin errors++; $display("FAIL zero_iss_ok: got %b exp 1", iss_ok); end
    tick(); idle();
    checks++; if (busy_vec !== '0 || err !== 1'b0) begin errors++; $display("FAIL zero_state: got %h/%b exp 0/0", busy_vec, err); end
  endtask

  task automatic test_err();
    wr_en = 1; waddr = 9; wdata = 32'h0BADF00D; raddr = {5'd9, 5'd9};
    tick(); idle();
    checks++; if (err !== 1'b1 || rdata[0 +: XLEN] !== 32'h0BADF00D) begin errors++; $display("FAIL err_set: got %b/%h exp 1/0badf00d", err, rdata[0 +: XLEN]); end
    iss_en = 1; iss_addr = 4; tick(); idle();
    wr_en = 1; waddr = 4; wdata = 32'h44; tick(); idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", err); end
    @(negedge clock); reset = 1; model_reset(); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b exp 0", err); end
    @(negedge clock); reset = 0;
  endtask

  task automatic test_random();
    int q[$];
    for (int i = 0; i < 400; i++) begin
      q.delete();
      for (int r = 1; r < NREG; r++) if (m_busy[r]) q.push_back(r);
      wr_en = ($urandom_range(0, 1) == 1);
      if (q.size() > 0 && $urandom_range(0, 9) < 8) waddr = AW'(q[$urandom_range(0, q.size()-1)]);
      else waddr = AW'($urandom_range(0, NREG-1));
      wdata = $urandom;
      iss_en = ($urandom_range(0, 1) == 1);
      iss_addr = AW'($urandom_range(0, NREG-1));
      for (int p = 0; p < NRD; p++)
        raddr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NREG-1));
      #1;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rdata[p*XLEN +: XLEN] !== exp_rdata(int'(raddr[p*AW +: AW])) || rbusy[p] !== exp_rbusy(int'(raddr[p*AW +: AW]))) begin
          errors++;
          $display("FAIL rand_rd%0d cyc %0d addr %0d: got %h/%b exp %h/%b", p, i, raddr[p*AW +: AW],
                   rdata[p*XLEN +: XLEN], rbusy[p], exp_rdata(int'(raddr[p*AW +: AW])), exp_rbusy(int'(raddr[p*AW +: AW])));
        end
      end
      checks++;
      if (iss_ok !== exp_iss_ok() || busy_vec !== exp_bv() || err !== m_err) begin
        errors++;
        $display("FAIL rand_state cyc %0d: got ok %b bv %h err %b exp ok %b bv %h err %b",
                 i, iss_ok, busy_vec, err, exp_iss_ok(), exp_bv(), m_err);
      end
      if (i == 200) begin
        #2 reset = 1; model_reset(); #1;
        checks++; if (busy_vec !== '0 || err !== 1'b0) begin errors++; $display("FAIL rand_reset: got %h/%b exp 0/0", busy_vec, err); end
        @(negedge clock); reset = 0;
      end else begin
        tick();
      end
    end
    idle();
  endtask

  task automatic test_sweep();
    logic [XB-1:0] d2, d15;
    d2 = 64'h0123456789ABCDEF; d15 = 64'hFEDCBA9876543210;
    iss_en_b = 1; iss_addr_b = 2; tick();
    iss_addr_b = 15; tick(); iss_en_b = 0;
    raddr_b = {4'd0, 4'd15, 4'd2, 4'd2};
    wr_en_b = 1; waddr_b = 2; wdata_b = d2; #1;
    checks++; if (rdata_b[0 +: XB] !== d2 || rdata_b[XB +: XB] !== d2 || rbusy_b[1:0] !== 2'b00)
      begin errors++; $display("FAIL sweep_r2: got %h/%h/%b exp %h", rdata_b[0 +: XB], rdata_b[XB +: XB], rbusy_b[1:0], d2); end
    checks++; if (rdata_b[2*XB +: XB] !== '0 || rbusy_b[2] !== 1'b1 || rdata_b[3*XB +: XB] !== '0 || rbusy_b[3] !== 1'b0)
      begin errors++; $display("FAIL sweep_r15r0: got %h/%b %h/%b exp 0/1 0/0", rdata_b[2*XB +: XB], rbusy_b[2], rdata_b[3*XB +: XB], rbusy_b[3]); end
    tick();
    waddr_b = 15; wdata_b = d15; #1;
    checks++; if (rdata_b[2*XB +: XB] !== d15 || rbusy_b[2] !== 1'b0 || rdata_b[0 +: XB] !== d2 || rdata_b[XB +: XB] !== d2)
      begin errors++; $display("FAIL sweep_byp15: got %h/%b %h exp %h/0 %h", rdata_b[2*XB +: XB], rbusy_b[2], rdata_b[0 +: XB], d15, d2); end
    tick();
    waddr_b = 0; wdata_b = '1; #1;
    checks++; if (rdata_b[3*XB +: XB] !== '0 || rbusy_b[3] !== 1'b0) begin errors++; $display("FAIL sweep_r0: got %h/%b exp 0/0", rdata_b[3*XB +: XB], rbusy_b[3]); end
    tick(); idle();
    checks++; if (busy_vec_b !== '0 || err_b !== 1'b0) begin errors++; $display("FAIL sweep_state: got %h/%b exp 0/0", busy_vec_b, err_b); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_issue_wb();
    test_same_edge();
    test_zero();
    test_err();
    test_random();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
